exchanger_avalon_bridge: RTL and testbench
==========================================

# exchanger_avalon_bridge

Avalon-MM slave bridge between the HPS lightweight bus and the ARM port of the ARM/NIOS exchange RAM. It turns bus reads and writes into RAM port-A accesses, absorbs the RAM's registered read latency with `waitrequest`, and blocks ARM writes to the NIOS-owned words 8–15. It also snoops the NIOS port to keep a per-word "new data" mask and drives an interrupt to the ARM.

## Interface
**Parameters**
- `RAM_LATENCY`, default 1: clocks from RAM address to valid `q_a`; legal values 1–2.
- `BRIDGE_ID`, default 32'h45584331: constant returned at register 0x13.

**Ports**
- `clk`, in, 1: single clock, shared with the exchange RAM and the NIOS port.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `avs_address`, in, 5: bit 4 = 0 selects RAM word [3:0]; bit 4 = 1 selects control register.
- `avs_read`, in, 1: Avalon read request; held until `waitrequest` is low.
- `avs_write`, in, 1: Avalon write request.
- `avs_writedata`, in, 32: write data.
- `avs_readdata`, out, 32: registered read data.
- `avs_waitrequest`, out, 1: stall signal.
- `ARM_DATA_FROM`, out, 32: RAM port-A write data.
- `ARM_DATA_TO`, in, 32: RAM port-A read data (`q_a`).
- `ARM_SEL`, out, 4: RAM port-A address.
- `ARM_WR`, out, 1: RAM port-A write enable.
- `NIOS_SEL`, in, 4: snooped NIOS address.
- `NIOS_WR`, in, 1: snooped NIOS write strobe.
- `irq`, out, 1: registered level interrupt to the ARM.

## Operation
- **FSM states:** IDLE, RD_WAIT, RD_CAPT, RD_RESP.
- **IDLE + `avs_write`:**
  - Accepted in one cycle with `waitrequest` = 0.
  - RAM address 0–7: `ARM_WR` = 1 in the same cycle, with `ARM_SEL` = `avs_address[3:0]` and `ARM_DATA_FROM` = `avs_writedata`.
  - RAM address 8–15: `ARM_WR` = 0 and `reject_cnt` increments.
  - Control address: the register write is applied.
- **IDLE + `avs_read`:**
  - `ARM_SEL` = `avs_address[3:0]`.
  - `waitrequest` = 1.
  - Go to RD_WAIT, or straight to RD_CAPT when `RAM_LATENCY` = 1.
- **RD_WAIT:** one extra cycle; entered only when `RAM_LATENCY` = 2. Then go to RD_CAPT.
- **RD_CAPT:**
  - `avs_readdata` <= `ARM_DATA_TO` for a RAM read, or the selected control register value.
  - `waitrequest` = 1.
  - Go to RD_RESP.
- **RD_RESP:** `waitrequest` = 0 with `avs_read` still high, then return to IDLE.
- **Read/write overlap:** if `avs_read` and `avs_write` are both high in IDLE, the read wins and the write is ignored (protocol violation).
- **`ARM_SEL` hold:** `ARM_SEL` keeps the read address from acceptance through RD_RESP.
- **Control registers** (`avs_address[3:0]` with bit 4 = 1):
  - 0x10 DIRTY, [7:0]: bit i is set when the NIOS writes word 8+i. Writing 1 clears a bit (W1C). Bits [31:8] read 0.
  - 0x11 IRQ_EN, [7:0]: read/write, reset 0.
  - 0x12 REJECT_CNT, [7:0]: saturates at 255. Any write clears it.
  - 0x13 ID: reads `BRIDGE_ID`; writes are ignored.
  - 0x14–0x1F: read 0; writes are ignored.
- **NIOS snoop:** `NIOS_WR` && `NIOS_SEL` >= 8 sets `DIRTY[NIOS_SEL-8]` every cycle, regardless of bridge state.
- **Set/clear collision:** a snoop set and an ARM W1C on the same bit in the same cycle leaves the bit set (set wins).
- **Saturation collision:** a reject on the same cycle the counter is at 255 leaves it at 255.
- **`irq`:** irq <= |(DIRTY & IRQ_EN), registered, so it follows the mask by one clock.

## Timing
- **Reset values:**
  - `avs_readdata` = 0.
  - `avs_waitrequest` = 0 while IDLE with no read.
  - `ARM_WR` = 0, `ARM_SEL` = 0, `ARM_DATA_FROM` = 0, `irq` = 0.
  - DIRTY = 0, IRQ_EN = 0, REJECT_CNT = 0.
  - FSM returns to IDLE.
- **Write path:** `ARM_WR`, `ARM_SEL` and `ARM_DATA_FROM` are combinational from the Avalon inputs in IDLE. The RAM samples them on the same edge.
- **Read latency:** `RAM_LATENCY` + 2 cycles from read assertion to the cycle with `waitrequest` low. That is 3 cycles for the default.
- **`avs_waitrequest`:**
  - Equals `avs_read` in IDLE.
  - Is 1 in RD_WAIT and RD_CAPT.
  - Is 0 in RD_RESP.
- **Reset mid-read:** reset asserted during a read aborts it; after release the master must re-issue the read.
- **Reset and writes:** writes are not blocked while a read is outstanding, because the master cannot issue them.

## Test plan
- **Write then read, RAM word 3:** write 32'hDEADBEEF to 0x03, then read 0x03.
  - The write pulses `ARM_WR` one cycle with `ARM_SEL` = 3.
  - The read returns 32'hDEADBEEF with `waitrequest` high for exactly 2 cycles (`RAM_LATENCY` = 1).
- **Write protection:** write 32'h1 to 0x09.
  - `ARM_WR` stays 0.
  - A read of 0x12 returns 1.
  - 256 further writes to 0x09 leave REJECT_CNT at 255.
- **NIOS snoop and interrupt:** NIOS writes word 10, then IRQ_EN = 8'h04 is written.
  - DIRTY reads 8'h04.
  - `irq` rises the cycle after the IRQ_EN write.
  - Writing 8'h04 to 0x10 clears DIRTY, and `irq` falls one cycle later.
- **Set/clear collision:** NIOS write to word 8 in the same cycle as an ARM W1C of DIRTY bit 0 → DIRTY[0] stays 1.
- **Reset mid-read:** assert `reset_n` = 0 in RD_CAPT.
  - After release: FSM in IDLE, `waitrequest` = 0, `avs_readdata` = 0, `irq` = 0.
  - The next read of 0x13 returns 32'h45584331.
- **Latency 2:** with `RAM_LATENCY` = 2, a read of RAM word 0 holds `waitrequest` high for 3 cycles and returns the RAM contents.

Source files
------------

// File: rtl/exchanger_avalon_bridge.sv
// Avalon-MM slave bridge onto port A of the ARM/NIOS exchange RAM.
// It write-protects NIOS-owned words 8-15 and snoops NIOS writes to raise an ARM interrupt.
module exchanger_avalon_bridge #(
  parameter int unsigned RAM_LATENCY = 1,
  parameter logic [31:0] BRIDGE_ID   = 32'h45584331
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [31:0] ARM_DATA_FROM,
  input  logic [31:0] ARM_DATA_TO,
  output logic [3:0]  ARM_SEL,
  output logic        ARM_WR,
  input  logic [3:0]  NIOS_SEL,
  input  logic        NIOS_WR,
  output logic        irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned MW = 8;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAPT, RD_RESP} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [MW-1:0]   dirty_q, dirty_d;
  logic [MW-1:0]   irq_en_q, irq_en_d;
  logic [MW-1:0]   reject_q, reject_d;
  logic            irq_q;
  logic            wr_acc;
  logic [MW-1:0]   snoop_set, w1c;
  logic [DW-1:0]   reg_rdata;

  // Control register read mux, addressed by the address latched at read acceptance
  always_comb begin
    reg_rdata = '0;
    case (addr_q[3:0])
      4'h0:    reg_rdata = DW'(dirty_q);
      4'h1:    reg_rdata = DW'(irq_en_q);
      4'h2:    reg_rdata = DW'(reject_q);
      4'h3:    reg_rdata = BRIDGE_ID;
      default: reg_rdata = '0;
    endcase
  end

  // Bus FSM; the write path and RAM address are combinational from the bus in IDLE
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    rdata_d         = rdata_q;
    avs_waitrequest = 1'b0;
    ARM_WR          = 1'b0;
    ARM_SEL         = addr_q[3:0];
    ARM_DATA_FROM   = '0;
    wr_acc          = 1'b0;
    case (state_q)
      IDLE: begin
        ARM_SEL = 4'd0;
        if (avs_read) begin
          avs_waitrequest = 1'b1;
          ARM_SEL         = avs_address[3:0];
          addr_d          = avs_address;
          state_d         = (RAM_LATENCY >= 2) ? RD_WAIT : RD_CAPT;
        end else if (avs_write) begin
          wr_acc  = 1'b1;
          ARM_SEL = avs_address[3:0];
          if (!avs_address[4] && !avs_address[3]) begin
            ARM_WR        = 1'b1;
            ARM_DATA_FROM = avs_writedata;
          end
        end
      end
      RD_WAIT: begin
        avs_waitrequest = 1'b1;
        state_d         = RD_CAPT;
      end
      RD_CAPT: begin
        avs_waitrequest = 1'b1;
        rdata_d         = addr_q[4] ? reg_rdata : ARM_DATA_TO;
        state_d         = RD_RESP;
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register file updates; a snoop set overrides a same-cycle W1C
  always_comb begin
    snoop_set = '0;
    w1c       = '0;
    irq_en_d  = irq_en_q;
    reject_d  = reject_q;
    if (NIOS_WR && NIOS_SEL[3]) snoop_set[NIOS_SEL[2:0]] = 1'b1;
    if (wr_acc && avs_address[4]) begin
      case (avs_address[3:0])
        4'h0:    w1c      = avs_writedata[MW-1:0];
        4'h1:    irq_en_d = avs_writedata[MW-1:0];
        4'h2:    reject_d = '0;
        default: ;
      endcase
    end
    if (wr_acc && !avs_address[4] && avs_address[3] && (reject_q != 8'hFF))
      reject_d = reject_q + 8'd1;
    dirty_d = (dirty_q & ~w1c) | snoop_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rdata_q  <= '0;
      dirty_q  <= '0;
      irq_en_q <= '0;
      reject_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      dirty_q  <= dirty_d;
      irq_en_q <= irq_en_d;
      reject_q <= reject_d;
      irq_q    <= |(dirty_q & irq_en_q);
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_exchanger_avalon_bridge.sv
// Randomized bench for exchanger_avalon_bridge against a word/register-level model.
// Two instances (RAM latency 1 and 2) share one exchange RAM model; use2 selects the bus target.
module tb_exchanger_avalon_bridge;

  localparam logic [31:0] ID = 32'h45584331;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  avs_address = '0;
  logic        avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  nios_sel = '0;
  logic        nios_wr = 1'b0;
  logic [31:0] nios_data = '0;
  logic        use2 = 1'b0;

  logic [31:0] rd1, rd2, from1, from2, q2a;
  logic [31:0] q1 = '0, q2 = '0;
  logic        wt1, wt2, wr1, wr2, irq1, irq2;
  logic [3:0]  sel1, sel2;
  logic [31:0] ram [16];

  exchanger_avalon_bridge #(.RAM_LATENCY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_read(avs_read & ~use2), .avs_write(avs_write & ~use2),
    .avs_writedata(avs_writedata), .avs_readdata(rd1), .avs_waitrequest(wt1),
    .ARM_DATA_FROM(from1), .ARM_DATA_TO(q1), .ARM_SEL(sel1), .ARM_WR(wr1),
    .NIOS_SEL(nios_sel), .NIOS_WR(nios_wr), .irq(irq1));

  exchanger_avalon_bridge #(.RAM_LATENCY(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address),
    .avs_read(avs_read & use2), .avs_write(avs_write & use2),
    .avs_writedata(avs_writedata), .avs_readdata(rd2), .avs_waitrequest(wt2),
    .ARM_DATA_FROM(from2), .ARM_DATA_TO(q2), .ARM_SEL(sel2), .ARM_WR(wr2),
    .NIOS_SEL(nios_sel), .NIOS_WR(nios_wr), .irq(irq2));

  // Exchange RAM: registered read on port A, one extra stage for the latency-2 instance
  always @(posedge clk) begin
    if (wr1) ram[sel1] <= from1;
    if (wr2) ram[sel2] <= from2;
    if (nios_wr) ram[nios_sel] <= nios_data;
    q1  <= ram[sel1];
    q2a <= ram[sel2];
    q2  <= q2a;
  end

  logic        obs_wait, obs_wr, obs_irq;
  logic [3:0]  obs_sel;
  logic [31:0] obs_from, obs_rdata;
  assign obs_wait  = use2 ? wt2 : wt1;
  assign obs_wr    = use2 ? wr2 : wr1;
  assign obs_irq   = use2 ? irq2 : irq1;
  assign obs_sel   = use2 ? sel2 : sel1;
  assign obs_from  = use2 ? from2 : from1;
  assign obs_rdata = use2 ? rd2 : rd1;

  logic [31:0] m_mem [16];
  logic [7:0]  m_dirty = '0, m_en = '0, m_reject = '0;
  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (!a[4]) return m_mem[a[3:0]];
    case (a[3:0])
      4'h0:    return 32'(m_dirty);
      4'h1:    return 32'(m_en);
      4'h2:    return 32'(m_reject);
      4'h3:    return ID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    logic ram_wr;
    ram_wr = !a[4] && !a[3];
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    #1;
    check_eq("wr_wait", 32'(obs_wait), 32'd0);
    check_eq("wr_en", 32'(obs_wr), 32'(ram_wr));
    if (ram_wr) begin
      check_eq("wr_sel", 32'(obs_sel), 32'(a[3:0]));
      check_eq("wr_data", obs_from, d);
    end
    @(posedge clk); #1;
    avs_write = 1'b0;
    if (ram_wr) m_mem[a[3:0]] = d;
    else if (!a[4]) m_reject = (m_reject == 8'hFF) ? 8'hFF : m_reject + 8'd1;
    else if (a[3:0] == 4'h0) m_dirty = m_dirty & ~d[7:0];
    else if (a[3:0] == 4'h1) m_en = d[7:0];
    else if (a[3:0] == 4'h2) m_reject = 8'd0;
  endtask

  task automatic bus_read(input logic [4:0] a, input int exp_wait);
    logic [31:0] exp;
    int n;
    exp = exp_read(a);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1; n = 0;
    #1;
    while (obs_wait && n < 20) begin
      check_eq("rd_sel", 32'(obs_sel), 32'(a[3:0]));
      n++;
      @(negedge clk); #1;
    end
    check_eq("rd_wait_cycles", 32'(n), 32'(exp_wait));
    check_eq("rd_sel_resp", 32'(obs_sel), 32'(a[3:0]));
    check_eq("rd_data", obs_rdata, exp);
    @(posedge clk); #1;
    avs_read = 1'b0;
  endtask

  task automatic nios_write(input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    nios_sel = s; nios_data = d; nios_wr = 1'b1;
    @(posedge clk); #1;
    nios_wr = 1'b0;
    m_mem[s] = d;
    if (s[3]) m_dirty[s[2:0]] = 1'b1;
  endtask

  task automatic check_irq_settled();
    @(posedge clk); #1;
    check_eq("irq", 32'(obs_irq), 32'(|(m_dirty & m_en)));
  endtask

  initial begin
    logic [31:0] d;
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", obs_rdata, 32'd0);
    check_eq("rst_wait", 32'(obs_wait), 32'd0);
    check_eq("rst_arm_wr", 32'(obs_wr), 32'd0);
    check_eq("rst_arm_sel", 32'(obs_sel), 32'd0);
    check_eq("rst_arm_data", obs_from, 32'd0);
    check_eq("rst_irq", 32'(obs_irq), 32'd0);
    reset_n = 1'b1;
    bus_read(5'h10, 2);
    bus_read(5'h11, 2);
    bus_read(5'h12, 2);

    // Populate every RAM word, then clear the dirty mask
    for (int i = 0; i < 8; i++) bus_write(5'(i), $urandom);
    for (int i = 8; i < 16; i++) nios_write(4'(i), $urandom);
    bus_read(5'h10, 2);
    bus_write(5'h10, 32'hFF);

    // Write then read word 3
    bus_write(5'h03, 32'hDEADBEEF);
    bus_read(5'h03, 2);

    // Write protection
    bus_write(5'h09, 32'h1);
    bus_read(5'h12, 2);
    bus_read(5'h09, 2);

    // Snoop and interrupt timing
    nios_write(4'd10, $urandom);
    bus_write(5'h11, 32'h04);
    check_eq("irq_before", 32'(obs_irq), 32'd0);
    @(posedge clk); #1;
    check_eq("irq_rise", 32'(obs_irq), 32'd1);
    bus_read(5'h10, 2);
    bus_write(5'h10, 32'h04);
    check_eq("irq_hold", 32'(obs_irq), 32'd1);
    @(posedge clk); #1;
    check_eq("irq_fall", 32'(obs_irq), 32'd0);

    // Snoop set and W1C on the same bit in the same cycle
    nios_write(4'd8, $urandom);
    d = $urandom;
    @(negedge clk);
    nios_sel = 4'd8; nios_data = d; nios_wr = 1'b1;
    avs_address = 5'h10; avs_writedata = 32'h1; avs_write = 1'b1;
    @(posedge clk); #1;
    nios_wr = 1'b0; avs_write = 1'b0;
    m_mem[8] = d;
    m_dirty = (m_dirty & ~8'h01) | 8'h01;
    bus_read(5'h10, 2);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 2))
        0: bus_write(5'($urandom_range(0, 31)), $urandom);
        1: bus_read(5'($urandom_range(0, 31)), 2);
        default: nios_write(4'($urandom_range(0, 15)), $urandom);
      endcase
      check_irq_settled();
    end

    // Reject counter saturation and clear
    for (int k = 0; k < 256; k++) bus_write(5'h09, $urandom);
    bus_read(5'h12, 2);
    bus_write(5'h12, $urandom);
    bus_read(5'h12, 2);

    // Reset in the middle of a read
    bus_write(5'h11, 32'hFF);
    nios_write(4'd12, $urandom);
    check_irq_settled();
    check_eq("irq_pre_reset", 32'(obs_irq), 32'd1);
    bus_read(5'h13, 2);
    @(negedge clk);
    avs_address = 5'h13; avs_read = 1'b1;
    @(negedge clk);
    reset_n = 1'b0; avs_read = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_dirty = '0; m_en = '0; m_reject = '0;
    #1;
    check_eq("mid_rst_wait", 32'(obs_wait), 32'd0);
    check_eq("mid_rst_readdata", obs_rdata, 32'd0);
    check_eq("mid_rst_irq", 32'(obs_irq), 32'd0);
    bus_read(5'h13, 2);
    bus_read(5'h10, 2);

    // Latency-2 instance
    use2 = 1'b1;
    bus_write(5'h00, $urandom);
    bus_read(5'h00, 3);
    bus_read(5'h05, 3);
    use2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
